// File: rtl/jesd204_tx_error_injector_pkg.sv
// Shared encodings for the JESD204 TX error injector.
`default_nettype none

package jesd204_tx_error_injector_pkg;

  typedef enum logic [1:0] {
    MODE_OFF      = 2'd0,
    MODE_SINGLE   = 2'd1,
    MODE_BURST    = 2'd2,
    MODE_PERIODIC = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/jesd204_sat_event_counter.sv
// Saturating counter that adds the popcount of an event vector every cycle.
`default_nettype none

module jesd204_sat_event_counter #(
  parameter int NUM_EVENTS = 4,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic [NUM_EVENTS-1:0] events,
  output logic [CNT_WIDTH-1:0]  count
);

  // Extra headroom so the sum never wraps before the clamp is applied.
  localparam int SUM_WIDTH = CNT_WIDTH + $clog2(NUM_EVENTS + 1);
  localparam logic [SUM_WIDTH-1:0] MAX_COUNT =
    {{(SUM_WIDTH - CNT_WIDTH){1'b0}}, {CNT_WIDTH{1'b1}}};

  logic [SUM_WIDTH-1:0] pop;
  logic [SUM_WIDTH-1:0] sum;

  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_EVENTS; i++) begin
      pop = pop + SUM_WIDTH'(events[i]);
    end
    sum = SUM_WIDTH'(count) + pop;
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (sum > MAX_COUNT) begin
      count <= '1;
    end else begin
      count <= sum[CNT_WIDTH-1:0];
    end
  end

endmodule

`default_nettype wire

// File: rtl/jesd204_tx_error_injector.sv
// Flips a selected bit in chosen 8b10b symbols on a single/burst/periodic schedule.
`default_nettype none

module jesd204_tx_error_injector
  import jesd204_tx_error_injector_pkg::*;
#(
  parameter int NUM_SYMBOLS  = 4,
  parameter int SYMBOL_WIDTH = 10,
  parameter int LEN_WIDTH    = 16,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                active,
  input  logic [NUM_SYMBOLS*SYMBOL_WIDTH-1:0] in_symbols,
  output logic [NUM_SYMBOLS*SYMBOL_WIDTH-1:0] out_symbols,
  input  logic [1:0]                          cfg_mode,
  input  logic [NUM_SYMBOLS-1:0]              cfg_symbol_mask,
  input  logic [$clog2(SYMBOL_WIDTH)-1:0]     cfg_bit_sel,
  input  logic [LEN_WIDTH-1:0]                cfg_burst_len,
  input  logic [LEN_WIDTH-1:0]                cfg_period,
  input  logic                                start,
  input  logic                                stop,
  output logic                                busy,
  output logic                                done,
  output logic [CNT_WIDTH-1:0]                status_inj_cnt
);

  localparam int BSEL_WIDTH = $clog2(SYMBOL_WIDTH);
  localparam int DATA_WIDTH = NUM_SYMBOLS * SYMBOL_WIDTH;

  state_e                 state_q, state_d;
  mode_e                  mode_q;
  logic [NUM_SYMBOLS-1:0] mask_q;
  logic [BSEL_WIDTH-1:0]  bit_sel_q;
  logic [LEN_WIDTH-1:0]   period_q;
  logic [LEN_WIDTH-1:0]   remaining_q, remaining_d;
  logic [LEN_WIDTH-1:0]   gap_q, gap_d;
  logic                   done_d;
  logic                   accept;
  logic [NUM_SYMBOLS-1:0] inj_vec;
  logic [BSEL_WIDTH-1:0]  bit_eff;
  logic [SYMBOL_WIDTH-1:0] bit_onehot;
  logic [DATA_WIDTH-1:0]  flip;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    gap_d       = gap_q;
    done_d      = 1'b0;
    accept      = 1'b0;
    inj_vec     = (state_q == ST_RUN && active) ? mask_q : '0;
    case (state_q)
      ST_IDLE: begin
        if (start && !stop && cfg_mode != MODE_OFF) begin
          accept  = 1'b1;
          state_d = ST_RUN;
          if (cfg_mode == MODE_BURST && cfg_burst_len != '0) begin
            remaining_d = cfg_burst_len;
          end else begin
            remaining_d = LEN_WIDTH'(1);
          end
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (active) begin
          if (mode_q == MODE_PERIODIC) begin
            if (period_q > LEN_WIDTH'(1)) begin
              state_d = ST_GAP;
              gap_d   = period_q - LEN_WIDTH'(1);
            end
          end else begin
            remaining_d = remaining_q - LEN_WIDTH'(1);
            if (remaining_q == LEN_WIDTH'(1)) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end
          end
        end
      end
      ST_GAP: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (active) begin
          if (gap_q == LEN_WIDTH'(1)) begin
            state_d = ST_RUN;
          end else begin
            gap_d = gap_q - LEN_WIDTH'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      gap_q       <= '0;
      done        <= 1'b0;
      mode_q      <= MODE_OFF;
      mask_q      <= '0;
      bit_sel_q   <= '0;
      period_q    <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      gap_q       <= gap_d;
      done        <= done_d;
      if (accept) begin
        mode_q    <= mode_e'(cfg_mode);
        mask_q    <= cfg_symbol_mask;
        bit_sel_q <= cfg_bit_sel;
        period_q  <= cfg_period;
      end
    end
  end

  assign busy = (state_q != ST_IDLE);

  // Out-of-range bit selects fall back to bit 0.
  assign bit_eff = (int'(bit_sel_q) >= SYMBOL_WIDTH) ? '0 : bit_sel_q;

  always_comb begin
    bit_onehot          = '0;
    bit_onehot[bit_eff] = 1'b1;
  end

  for (genvar i = 0; i < NUM_SYMBOLS; i++) begin : g_flip
    assign flip[i*SYMBOL_WIDTH +: SYMBOL_WIDTH] = inj_vec[i] ? bit_onehot : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_symbols <= '0;
    end else begin
      out_symbols <= in_symbols ^ flip;
    end
  end

  jesd204_sat_event_counter #(
    .NUM_EVENTS (NUM_SYMBOLS),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_inj_counter (
    .clk    (clk),
    .reset  (reset),
    .clear  (accept),
    .events (inj_vec),
    .count  (status_inj_cnt)
  );

endmodule

`default_nettype wire

// File: tb/tb_jesd204_tx_error_injector.sv
// Randomized + directed bench against an active-beat-index reference model.
`default_nettype none

module tb_jesd204_tx_error_injector;

  logic        clk = 1'b0;
  logic        reset, active, start, stop;
  logic [39:0] in_symbols;
  logic [1:0]  cfg_mode;
  logic [3:0]  cfg_symbol_mask;
  logic [3:0]  cfg_bit_sel;
  logic [15:0] cfg_burst_len, cfg_period;
  logic [39:0] out_symbols, out4;
  logic        busy, done, busy4, done4;
  logic [31:0] cnt;
  logic [3:0]  cnt4;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  jesd204_tx_error_injector dut (
    .clk(clk), .reset(reset), .active(active), .in_symbols(in_symbols),
    .out_symbols(out_symbols), .cfg_mode(cfg_mode), .cfg_symbol_mask(cfg_symbol_mask),
    .cfg_bit_sel(cfg_bit_sel), .cfg_burst_len(cfg_burst_len), .cfg_period(cfg_period),
    .start(start), .stop(stop), .busy(busy), .done(done), .status_inj_cnt(cnt)
  );

  jesd204_tx_error_injector #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .active(active), .in_symbols(in_symbols),
    .out_symbols(out4), .cfg_mode(cfg_mode), .cfg_symbol_mask(cfg_symbol_mask),
    .cfg_bit_sel(cfg_bit_sel), .cfg_burst_len(cfg_burst_len), .cfg_period(cfg_period),
    .start(start), .stop(stop), .busy(busy4), .done(done4), .status_inj_cnt(cnt4)
  );

  // Model: a sequence injects on its first N active beats (single/burst) or on
  // every active beat whose index since start is a multiple of the period.
  bit          m_run = 1'b0;
  logic [1:0]  m_mode;
  logic [3:0]  m_mask;
  int          m_bit, m_len, m_per, act_idx;
  longint      raw = 0;
  logic [39:0] e_out;
  bit          e_busy, e_done;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic [3:0]  inj;
    logic [39:0] o;
    bit          fin;
    inj = (m_run && active && (m_mode != 2'd3 || (act_idx % m_per) == 0)) ? m_mask : 4'h0;
    o = in_symbols;
    for (int i = 0; i < 4; i++) if (inj[i]) o[i*10 + m_bit] = ~o[i*10 + m_bit];
    if (reset) begin
      e_out = '0; e_busy = 0; e_done = 0; raw = 0; m_run = 0;
    end else begin
      e_out  = o;
      raw    = raw + $countones(inj);
      e_done = 0;
      if (!m_run) begin
        if (start && !stop && cfg_mode != 2'd0) begin
          m_run   = 1;
          m_mode  = cfg_mode;
          m_mask  = cfg_symbol_mask;
          m_bit   = (cfg_bit_sel >= 4'd10) ? 0 : int'(cfg_bit_sel);
          m_len   = (cfg_mode == 2'd1) ? 1 : ((cfg_burst_len == 0) ? 1 : int'(cfg_burst_len));
          m_per   = (cfg_period == 0) ? 1 : int'(cfg_period);
          act_idx = 0;
          raw     = 0;
        end
      end else begin
        fin = active && m_mode != 2'd3 && act_idx == m_len - 1;
        if (active) act_idx++;
        if (stop) m_run = 0;
        else if (fin) begin m_run = 0; e_done = 1; end
      end
      e_busy = m_run;
    end
    @(posedge clk);
    #1;
    check("out_symbols", out_symbols, e_out);
    check("busy", busy, e_busy);
    check("done", done, e_done);
    check("inj_cnt", cnt, (raw > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : raw);
    check("inj_cnt_w4", cnt4, (raw > 15) ? 64'd15 : raw);
    check("out_symbols_w4", out4, e_out);
  endtask

  task automatic set_cfg(input logic [1:0] mode, input logic [3:0] mask, input logic [3:0] bsel,
                         input logic [15:0] len, input logic [15:0] per);
    cfg_mode = mode; cfg_symbol_mask = mask; cfg_bit_sel = bsel;
    cfg_burst_len = len; cfg_period = per;
  endtask

  initial begin
    reset = 1; active = 0; start = 0; stop = 0; in_symbols = '0;
    set_cfg(2'd0, 4'h0, 4'd0, 16'd0, 16'd0);
    step(); step();
    reset = 0;

    // Idle pass-through, incrementing pattern
    for (int i = 0; i < 4; i++) begin
      in_symbols = {10'(4*i+3), 10'(4*i+2), 10'(4*i+1), 10'(4*i)};
      active = (i % 2) == 0;
      step();
    end

    // Single
    in_symbols = {4{10'h17C}}; active = 1;
    set_cfg(2'd1, 4'b0101, 4'd0, 16'd0, 16'd0);
    start = 1; step(); start = 0;
    repeat (4) step();

    // Burst with an inactive beat; start while busy is ignored
    set_cfg(2'd2, 4'hF, 4'd3, 16'd3, 16'd0);
    start = 1; step(); start = 0;
    active = 1; step();
    active = 0; set_cfg(2'd3, 4'h1, 4'd9, 16'd9, 16'd1); start = 1; step(); start = 0;
    active = 1; step(); step(); step(); step();

    // Periodic, then stop
    set_cfg(2'd3, 4'b0001, 4'd9, 16'd0, 16'd4);
    start = 1; step(); start = 0;
    repeat (12) begin in_symbols = 40'({$urandom(), $urandom()}); step(); end
    stop = 1; step(); stop = 0;
    repeat (2) step();

    // Saturation on the 4-bit instance
    set_cfg(2'd3, 4'hF, 4'd12, 16'd0, 16'd1);
    start = 1; step(); start = 0;
    repeat (6) step();
    stop = 1; step(); stop = 0;

    // Mode off start, and start+stop together while idle
    set_cfg(2'd0, 4'hF, 4'd1, 16'd2, 16'd2);
    start = 1; step(); start = 0; step();
    set_cfg(2'd2, 4'hF, 4'd1, 16'd2, 16'd2);
    start = 1; stop = 1; step(); start = 0; stop = 0; step();

    // Reset mid-burst
    set_cfg(2'd2, 4'hA, 4'd5, 16'd10, 16'd0);
    start = 1; step(); start = 0;
    repeat (3) step();
    reset = 1; step(); reset = 0;
    repeat (4) step();

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      in_symbols = 40'({$urandom(), $urandom()});
      active = ($urandom_range(3, 0) != 0);
      start  = ($urandom_range(9, 0) == 0);
      stop   = ($urandom_range(39, 0) == 0);
      reset  = ($urandom_range(199, 0) == 0);
      if (start)
        set_cfg(2'($urandom_range(3, 0)), 4'($urandom()), 4'($urandom_range(15, 0)),
                16'($urandom_range(6, 0)), 16'($urandom_range(6, 0)));
      step();
    end
    reset = 0; start = 0; stop = 0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/jesd204_tx_error_injector.md
Name: jesd204_tx_error_injector

Overview:
- Transmit-side test block placed between the JESD204 TX 8b10b encoder output and the PHY.
- Flips one selected bit in chosen 10-bit symbols under a programmable single/burst/periodic schedule, so the receive link sees disparity and not-in-table errors.
- Keeps a saturating count of corrupted symbols that software compares directly against the receiver error count.
- Pass-through with fixed 1-cycle latency when idle.

Parameters:
- NUM_SYMBOLS, 4, symbols per beat per lane.
- SYMBOL_WIDTH, 10, bits per encoded symbol.
- LEN_WIDTH, 16, width of burst length / period fields.
- CNT_WIDTH, 32, injected-symbol counter width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- active  in  1  link in DATA phase; injection only on beats with active=1.
- in_symbols  in  NUM_SYMBOLS*SYMBOL_WIDTH  encoded symbols, symbol 0 in LSBs.
- out_symbols  out  NUM_SYMBOLS*SYMBOL_WIDTH  registered, possibly corrupted symbols.
- cfg_mode  in  2  0=off, 1=single, 2=burst, 3=periodic.
- cfg_symbol_mask  in  NUM_SYMBOLS  1 = corrupt this symbol position.
- cfg_bit_sel  in  $clog2(SYMBOL_WIDTH)  bit index flipped; values >= SYMBOL_WIDTH flip bit 0.
- cfg_burst_len  in  LEN_WIDTH  beats injected in burst mode.
- cfg_period  in  LEN_WIDTH  active-beat period in periodic mode.
- start  in  1  pulse; begins a sequence.
- stop  in  1  aborts a running sequence.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle pulse on normal completion.
- status_inj_cnt  out  CNT_WIDTH  saturating count of corrupted symbols.

Behaviour:
- Reset (synchronous, active-high, clock clk) values: out_symbols=0, busy=0, done=0, status_inj_cnt=0, state=IDLE.
- Datapath: out_symbols <= in_symbols ^ flip, where flip has bit cfg_bit_sel set in each symbol whose inj_vec bit is 1.
  - inj_vec = latched mask if (state==RUN && active), else 0.
  - Latency is exactly 1 cycle in all states.
- Config (mode, mask, bit_sel, burst_len, period) is latched on an accepted start and ignored while busy.
- IDLE:
  - start && cfg_mode!=0 -> RUN, busy=1 next cycle, status_inj_cnt cleared to 0.
  - remaining = 1 in single mode; remaining = max(burst_len,1) in burst mode.
  - start with cfg_mode==0 is ignored.
- RUN, active beat (inject):
  - Single/burst: remaining-1. If remaining==1 -> IDLE, busy=0 and done=1 at the same edge as the last corrupted beat appears.
  - Periodic: if period<=1 stay in RUN. Otherwise -> GAP with gap=period-1.
- RUN, inactive beat: no injection, no decrement, state held.
- GAP: each active beat decrements gap; gap==1 on an active beat -> RUN. Inactive beats hold gap.
- Periodic mode runs until stop.
- stop in RUN/GAP -> IDLE next edge, busy=0, done stays 0. Any injection in that same cycle still occurs.
- start and stop in the same cycle while IDLE: stop wins, start is ignored.
- start while busy: ignored.
- Counter: status_inj_cnt <= min(cnt + popcount(inj_vec), 2^CNT_WIDTH-1), updated on the same edge as out_symbols.
  - Counter is never wrapped.
  - Counter holds after completion until the next accepted start or reset.
- Reset mid-sequence: immediate IDLE; every output returns to its reset value at the next edge.

Decomposition:
- Shared package: mode encodings (MODE_OFF/SINGLE/BURST/PERIODIC), state encodings (IDLE/RUN/GAP).
- One natural sub-module: jesd204_sat_event_counter. Takes a NUM_SYMBOLS-wide event vector, a clear input and reset; outputs a CNT_WIDTH saturating count (popcount + clamp).

Test Plan:
- Single:
  - Stimulus: mode=1, mask=4'b0101, bit_sel=0, in_symbols constant 0x17C per symbol, active=1, start pulse.
  - Response: exactly one output beat has symbols 0 and 2 = 0x17D; done pulses with that beat; status_inj_cnt=2; busy=0 afterwards.
- Burst with gaps:
  - Stimulus: mode=2, burst_len=3, mask=4'hF, active pattern 1,0,1,1.
  - Response: corruption on the three active beats only; the inactive beat passes untouched; cnt=12; one done pulse.
- Periodic:
  - Stimulus: mode=3, period=4, mask=4'b0001, bit_sel=9, 12 active beats, then stop.
  - Response: beats 0, 4 and 8 are corrupted (bit 9 of symbol 0); cnt=3; busy falls after stop; done never asserts.
- Saturation:
  - Stimulus: CNT_WIDTH=4, mode=3, period=1, mask=4'hF, active=1.
  - Response: cnt sequence 4, 8, 12, 15, 15, 15.
- Robustness:
  - start while busy: ignored, latched config unchanged.
  - start with mode=0: busy stays 0.
  - reset asserted mid-burst: next edge out_symbols=0, busy=0, cnt=0, and no further injection after reset releases.
- Latency: idle pass-through of an incrementing symbol pattern appears unchanged exactly 1 cycle later.
